// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/stage-control unit: PC source
// select codes, memory-wait FSM states and operand forwarding selects.
package pipe_hazard_ctrl_pkg;

    // PC source select
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_JR     = 2'd3;

    // Memory-wait FSM states
    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT   = 2'd1;
    localparam logic [1:0] ST_REDIR_PEND = 2'd2;

    // Per-operand forwarding source
    localparam logic [1:0] FWD_RF      = 2'd0;
    localparam logic [1:0] FWD_EXE     = 2'd1;
    localparam logic [1:0] FWD_MEM_ALU = 2'd2;
    localparam logic [1:0] FWD_MEM_LD  = 2'd3;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Single-operand dependency check against the EXE and MEM destinations.
// Returns the forwarding source and whether a load-use stall is needed.
module fwd_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] i_addr,
    input  logic            i_used,
    input  logic            i_skip,
    input  logic            i_exe_wen,
    input  logic            i_exe_is_load,
    input  logic [RA_W-1:0] i_exe_waddr,
    input  logic            i_mem_wen,
    input  logic            i_mem_is_load,
    input  logic [RA_W-1:0] i_mem_waddr,
    output logic [1:0]      o_fwd,
    output logic            o_stall
);

    logic w_act;
    assign w_act = i_used && (i_addr != '0) && !i_skip;

    // Nearest producing stage wins; an EXE load cannot forward and stalls instead
    always_comb begin
        o_fwd   = FWD_RF;
        o_stall = 1'b0;
        if (w_act) begin
            if (i_exe_wen && (i_exe_waddr == i_addr)) begin
                if (i_exe_is_load) o_stall = 1'b1;
                else               o_fwd   = FWD_EXE;
            end else if (i_mem_wen && (i_mem_waddr == i_addr)) begin
                o_fwd = i_mem_is_load ? FWD_MEM_LD : FWD_MEM_ALU;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stage-control unit for the 5-stage pipeline: operand
// forwarding, load-use stall, memory-wait FSM with watchdog, redirect flush
// (deferred while memory is stalled). Optional build macro HAZARD_PERF_EN
// adds saturating performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RA_W        = 5,
    parameter int NUM_SRC     = 2,
    parameter int FLUSH_DEPTH = 1,
    parameter int TMO_W       = 8,
    parameter int TMO_MAX     = 200
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_SRC*RA_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]      id_src_used,
    input  logic                    id_is_store,
    input  logic                    exe_wen,
    input  logic                    exe_is_load,
    input  logic [RA_W-1:0]         exe_waddr,
    input  logic                    mem_wen,
    input  logic                    mem_is_load,
    input  logic                    mem_is_store,
    input  logic [RA_W-1:0]         mem_waddr,
    input  logic [RA_W-1:0]         mem_rt_addr,
    input  logic                    wb_wen,
    input  logic [RA_W-1:0]         wb_waddr,
    input  logic                    mem_req,
    input  logic                    mem_ack,
    input  logic                    redirect,
    output logic [2*NUM_SRC-1:0]    fwd_sel,
    output logic                    fwd_mem,
    output logic                    if_en,
    output logic                    id_en,
    output logic                    exe_en,
    output logic                    mem_en,
    output logic                    wb_en,
    output logic                    if_rst,
    output logic                    id_rst,
    output logic                    exe_rst,
    output logic                    mem_rst,
    output logic                    wb_rst,
    output logic                    load_stall,
    output logic                    mem_timeout
`ifdef HAZARD_PERF_EN
   ,output logic [31:0]             perf_stall_cyc,
    output logic [31:0]             perf_mem_cyc,
    output logic [15:0]             perf_flush_cnt
`endif
);

    localparam logic             FLUSH_ID = (FLUSH_DEPTH >= 2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

    logic [2*NUM_SRC-1:0] w_fwd;
    logic [NUM_SRC-1:0]   w_stall_vec;
    logic                 w_load_stall;
    logic                 w_in_wait;
    logic                 w_tmo;
    logic                 w_hold;
    logic                 w_flush;
    logic [1:0]           w_state_nxt;
    logic [1:0]           r_state;
    logic [TMO_W-1:0]     r_cnt;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        // Operand 1 of a store is its data, handled by the WB->MEM path
        localparam logic IS_OP1 = (gi == 1);
        fwd_match #(.RA_W(RA_W)) u_fwd_match (
            .i_addr        (id_src_addr[gi*RA_W +: RA_W]),
            .i_used        (id_src_used[gi]),
            .i_skip        (id_is_store & IS_OP1),
            .i_exe_wen     (exe_wen),
            .i_exe_is_load (exe_is_load),
            .i_exe_waddr   (exe_waddr),
            .i_mem_wen     (mem_wen),
            .i_mem_is_load (mem_is_load),
            .i_mem_waddr   (mem_waddr),
            .o_fwd         (w_fwd[2*gi +: 2]),
            .o_stall       (w_stall_vec[gi])
        );
    end

    assign w_load_stall = |w_stall_vec;
    assign w_in_wait    = (r_state != ST_RUN);
    assign w_tmo        = w_in_wait && !mem_ack && (r_cnt == TMO_LAST);
    // The exit cycle (ack or timeout) is not stalled, so a pending flush lands there
    assign w_hold       = w_in_wait ? !(mem_ack || w_tmo) : (mem_req && !mem_ack);
    assign w_flush      = !w_hold && (redirect || (r_state == ST_REDIR_PEND));

    // Next-state logic; a redirect seen on any stalled wait cycle is held until exit
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:        if (mem_req && !mem_ack)
                               w_state_nxt = redirect ? ST_REDIR_PEND : ST_MEM_WAIT;
            ST_MEM_WAIT:   if (mem_ack || w_tmo) w_state_nxt = ST_RUN;
                           else if (redirect)    w_state_nxt = ST_REDIR_PEND;
            ST_REDIR_PEND: if (mem_ack || w_tmo) w_state_nxt = ST_RUN;
            default:       w_state_nxt = ST_RUN;
        endcase
    end

    // FSM state and saturating watchdog counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_in_wait)       r_cnt <= '0;
            else if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
    end

    // Stage enables/resets by priority: memory hold, flush, load-use stall
    always_comb begin
        if_en   = 1'b1;
        id_en   = 1'b1;
        exe_en  = 1'b1;
        mem_en  = 1'b1;
        wb_en   = 1'b1;
        if_rst  = 1'b0;
        id_rst  = 1'b0;
        exe_rst = 1'b0;
        mem_rst = 1'b0;
        wb_rst  = 1'b0;
        if (!rst_n) begin
            if_rst  = 1'b1;
            id_rst  = 1'b1;
            exe_rst = 1'b1;
            mem_rst = 1'b1;
            wb_rst  = 1'b1;
        end else if (w_hold) begin
            if_en  = 1'b0;
            id_en  = 1'b0;
            exe_en = 1'b0;
            mem_en = 1'b0;
            wb_rst = 1'b1;
        end else if (w_flush) begin
            if_rst = 1'b1;
            id_rst = FLUSH_ID;
        end else if (w_load_stall) begin
            if_en   = 1'b0;
            id_en   = 1'b0;
            exe_rst = 1'b1;
        end
    end

    assign fwd_sel     = rst_n ? w_fwd : '0;
    assign fwd_mem     = rst_n && mem_is_store && wb_wen &&
                         (mem_rt_addr != '0) && (wb_waddr == mem_rt_addr);
    assign load_stall  = rst_n && w_load_stall;
    assign mem_timeout = rst_n && w_tmo;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_mem;
    logic [15:0] r_perf_flush;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_mem   <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_load_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
            if (w_hold && (r_perf_mem != '1))         r_perf_mem   <= r_perf_mem + 32'd1;
            if (w_flush && (r_perf_flush != '1))      r_perf_flush <= r_perf_flush + 16'd1;
        end
    end

    assign perf_stall_cyc = r_perf_stall;
    assign perf_mem_cyc   = r_perf_mem;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (FLUSH_DEPTH=2, TMO_MAX=5).
// Performance counters are checked when built with HAZARD_PERF_EN.
module tb_pipe_hazard_ctrl;

    localparam int RA_W        = 5;
    localparam int NUM_SRC     = 2;
    localparam int FLUSH_DEPTH = 2;
    localparam int TMO_W       = 8;
    localparam int TMO_MAX     = 5;

    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_LDS  = 5'b00111;
    localparam logic [4:0] EN_MEMW = 5'b00001;
    localparam logic [4:0] RS_NONE = 5'b00000;
    localparam logic [4:0] RS_LDS  = 5'b00100;
    localparam logic [4:0] RS_MEMW = 5'b00001;
    localparam logic [4:0] RS_FL   = 5'b11000;
    localparam logic [4:0] RS_ALL  = 5'b11111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic [NUM_SRC*RA_W-1:0] id_src_addr;
    logic [NUM_SRC-1:0]      id_src_used;
    logic                    id_is_store;
    logic                    exe_wen, exe_is_load;
    logic [RA_W-1:0]         exe_waddr;
    logic                    mem_wen, mem_is_load, mem_is_store;
    logic [RA_W-1:0]         mem_waddr, mem_rt_addr;
    logic                    wb_wen;
    logic [RA_W-1:0]         wb_waddr;
    logic                    mem_req, mem_ack, redirect;
    logic [2*NUM_SRC-1:0]    fwd_sel;
    logic                    fwd_mem;
    logic                    if_en, id_en, exe_en, mem_en, wb_en;
    logic                    if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic                    load_stall, mem_timeout;
`ifdef HAZARD_PERF_EN
    logic [31:0]             perf_stall_cyc, perf_mem_cyc;
    logic [15:0]             perf_flush_cnt;
`endif

    pipe_hazard_ctrl #(
        .RA_W(RA_W), .NUM_SRC(NUM_SRC), .FLUSH_DEPTH(FLUSH_DEPTH),
        .TMO_W(TMO_W), .TMO_MAX(TMO_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_src_addr(id_src_addr), .id_src_used(id_src_used), .id_is_store(id_is_store),
        .exe_wen(exe_wen), .exe_is_load(exe_is_load), .exe_waddr(exe_waddr),
        .mem_wen(mem_wen), .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
        .mem_waddr(mem_waddr), .mem_rt_addr(mem_rt_addr),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr),
        .mem_req(mem_req), .mem_ack(mem_ack), .redirect(redirect),
        .fwd_sel(fwd_sel), .fwd_mem(fwd_mem),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
        .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
        .load_stall(load_stall), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_EN
       ,.perf_stall_cyc(perf_stall_cyc), .perf_mem_cyc(perf_mem_cyc),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    typedef struct {
        logic       rstn;
        logic [9:0] src_addr;
        logic [1:0] src_used;
        logic       is_store;
        logic       exe_wen, exe_is_load;
        logic [4:0] exe_waddr;
        logic       mem_wen, mem_is_load, mem_is_store;
        logic [4:0] mem_waddr, mem_rt_addr;
        logic       wb_wen;
        logic [4:0] wb_waddr;
        logic       mem_req, mem_ack, redirect;
        logic [3:0] e_fwd;
        logic       e_fwd_mem, e_stall, e_tmo;
        logic [4:0] e_en, e_rst;
    } vec_t;

    vec_t  tbl[$];
    string tnm[$];
    vec_t  sb[$];
    string sb_nm[$];

    int checks   = 0;
    int failures = 0;
    int t_stall  = 0;
    int t_mem    = 0;
    int t_flush  = 0;

    function automatic vec_t idle();
        vec_t v;
        v.rstn = 1'b1; v.src_addr = '0; v.src_used = '0; v.is_store = 1'b0;
        v.exe_wen = 1'b0; v.exe_is_load = 1'b0; v.exe_waddr = '0;
        v.mem_wen = 1'b0; v.mem_is_load = 1'b0; v.mem_is_store = 1'b0;
        v.mem_waddr = '0; v.mem_rt_addr = '0; v.wb_wen = 1'b0; v.wb_waddr = '0;
        v.mem_req = 1'b0; v.mem_ack = 1'b0; v.redirect = 1'b0;
        v.e_fwd = '0; v.e_fwd_mem = 1'b0; v.e_stall = 1'b0; v.e_tmo = 1'b0;
        v.e_en = EN_ALL; v.e_rst = RS_NONE;
        return v;
    endfunction

    task automatic cmp(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, what, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input string nm);
        rst_n = v.rstn; id_src_addr = v.src_addr; id_src_used = v.src_used;
        id_is_store = v.is_store; exe_wen = v.exe_wen; exe_is_load = v.exe_is_load;
        exe_waddr = v.exe_waddr; mem_wen = v.mem_wen; mem_is_load = v.mem_is_load;
        mem_is_store = v.mem_is_store; mem_waddr = v.mem_waddr; mem_rt_addr = v.mem_rt_addr;
        wb_wen = v.wb_wen; wb_waddr = v.wb_waddr; mem_req = v.mem_req;
        mem_ack = v.mem_ack; redirect = v.redirect;
        sb.push_back(v);
        sb_nm.push_back(nm);
    endtask

    task automatic check_out();
        vec_t  e;
        string nm;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard actual=empty required=entry");
            return;
        end
        e  = sb.pop_front();
        nm = sb_nm.pop_front();
        cmp(nm, "fwd_sel",     32'(fwd_sel), 32'(e.e_fwd));
        cmp(nm, "fwd_mem",     32'(fwd_mem), 32'(e.e_fwd_mem));
        cmp(nm, "load_stall",  32'(load_stall), 32'(e.e_stall));
        cmp(nm, "mem_timeout", 32'(mem_timeout), 32'(e.e_tmo));
        cmp(nm, "en",  32'({if_en, id_en, exe_en, mem_en, wb_en}), 32'(e.e_en));
        cmp(nm, "rst", 32'({if_rst, id_rst, exe_rst, mem_rst, wb_rst}), 32'(e.e_rst));
        if (!e.rstn) begin
            t_stall = 0; t_mem = 0; t_flush = 0;
        end else begin
            if (e.e_stall)          t_stall++;
            if (e.e_en == EN_MEMW)  t_mem++;
            if (e.e_rst == RS_FL)   t_flush++;
        end
    endtask

    task automatic step(input vec_t v, input string nm);
        @(posedge clk);
        #1;
        drive(v, nm);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t v, rv;

        // Reset held with a pending request and live hazards: outputs forced
        rv = idle();
        rv.rstn = 1'b0; rv.mem_req = 1'b1; rv.src_addr = {5'd0, 5'd5}; rv.src_used = 2'b01;
        rv.exe_wen = 1'b1; rv.exe_waddr = 5'd5; rv.exe_is_load = 1'b1;
        rv.mem_is_store = 1'b1; rv.mem_rt_addr = 5'd7; rv.wb_wen = 1'b1; rv.wb_waddr = 5'd7;
        rv.e_rst = RS_ALL;
        #1;
        drive(rv, "rst0");
        @(negedge clk);
        check_out();
        step(rv, "rst1");
        step(rv, "rst2");
        step(idle(), "rst_rel");

        // Forwarding / stall / flush vectors, all from the RUN state
        v = idle(); v.src_addr = {5'd0, 5'd5}; v.src_used = 2'b01; v.exe_wen = 1'b1; v.exe_waddr = 5'd5;
        v.e_fwd = 4'b0001; tbl.push_back(v); tnm.push_back("exe_alu");
        v.exe_is_load = 1'b1; v.e_fwd = 4'b0000; v.e_stall = 1'b1; v.e_en = EN_LDS; v.e_rst = RS_LDS;
        tbl.push_back(v); tnm.push_back("load_use");
        v = idle(); v.src_addr = {5'd0, 5'd5}; v.src_used = 2'b01; v.mem_wen = 1'b1; v.mem_is_load = 1'b1;
        v.mem_waddr = 5'd5; v.e_fwd = 4'b0011; tbl.push_back(v); tnm.push_back("mem_load");
        v = idle(); v.src_addr = {5'd6, 5'd0}; v.src_used = 2'b10; v.mem_wen = 1'b1; v.mem_waddr = 5'd6;
        v.e_fwd = 4'b1000; tbl.push_back(v); tnm.push_back("mem_alu_op1");
        v = idle(); v.src_addr = {5'd0, 5'd5}; v.src_used = 2'b01; v.exe_wen = 1'b1; v.exe_waddr = 5'd5;
        v.mem_wen = 1'b1; v.mem_waddr = 5'd5; v.e_fwd = 4'b0001; tbl.push_back(v); tnm.push_back("nearest");
        v = idle(); v.src_used = 2'b01; v.exe_wen = 1'b1; v.exe_waddr = 5'd0;
        tbl.push_back(v); tnm.push_back("r0");
        v = idle(); v.src_addr = {5'd0, 5'd5}; v.src_used = 2'b00; v.exe_wen = 1'b1; v.exe_waddr = 5'd5;
        tbl.push_back(v); tnm.push_back("unused");
        v = idle(); v.is_store = 1'b1; v.src_addr = {5'd6, 5'd3}; v.src_used = 2'b11; v.exe_wen = 1'b1;
        v.exe_waddr = 5'd6; v.mem_wen = 1'b1; v.mem_is_load = 1'b1; v.mem_waddr = 5'd3;
        v.e_fwd = 4'b0011; tbl.push_back(v); tnm.push_back("store_skip");
        v = idle(); v.src_addr = {5'd6, 5'd3}; v.src_used = 2'b11; v.exe_wen = 1'b1; v.exe_is_load = 1'b1;
        v.exe_waddr = 5'd6; v.mem_wen = 1'b1; v.mem_waddr = 5'd3;
        v.e_fwd = 4'b0010; v.e_stall = 1'b1; v.e_en = EN_LDS; v.e_rst = RS_LDS;
        tbl.push_back(v); tnm.push_back("op1_load");
        v = idle(); v.src_addr = {5'd0, 5'd5}; v.src_used = 2'b01; v.exe_waddr = 5'd5;
        v.mem_wen = 1'b1; v.mem_waddr = 5'd5; v.e_fwd = 4'b0010; tbl.push_back(v); tnm.push_back("exe_nowen");
        v = idle(); v.mem_is_store = 1'b1; v.mem_rt_addr = 5'd7; v.wb_wen = 1'b1; v.wb_waddr = 5'd7;
        v.e_fwd_mem = 1'b1; tbl.push_back(v); tnm.push_back("fwd_mem");
        v.mem_rt_addr = 5'd0; v.wb_waddr = 5'd0; v.e_fwd_mem = 1'b0;
        tbl.push_back(v); tnm.push_back("fwd_mem_r0");
        v.mem_rt_addr = 5'd7; v.wb_waddr = 5'd7; v.wb_wen = 1'b0;
        tbl.push_back(v); tnm.push_back("fwd_mem_nowen");
        v = idle(); v.redirect = 1'b1; v.e_rst = RS_FL; tbl.push_back(v); tnm.push_back("redir");
        v = idle(); v.redirect = 1'b1; v.src_addr = {5'd0, 5'd5}; v.src_used = 2'b01; v.exe_wen = 1'b1;
        v.exe_is_load = 1'b1; v.exe_waddr = 5'd5; v.e_stall = 1'b1; v.e_rst = RS_FL;
        tbl.push_back(v); tnm.push_back("redir_over_ld");
        v = idle(); v.mem_req = 1'b1; v.mem_ack = 1'b1; tbl.push_back(v); tnm.push_back("same_ack");

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], tnm[i]);

        // Memory wait acked on the 5th cycle: exactly 4 stalled cycles
        v = idle(); v.mem_req = 1'b1; v.e_en = EN_MEMW; v.e_rst = RS_MEMW;
        for (int i = 0; i < 4; i++) step(v, $sformatf("mw%0d", i));
        v = idle(); v.mem_req = 1'b1; v.mem_ack = 1'b1; step(v, "mw_ack");
        step(idle(), "mw_after");

        // Redirect during wait (twice) gives a single flush on the ack cycle
        v = idle(); v.mem_req = 1'b1; v.e_en = EN_MEMW; v.e_rst = RS_MEMW;
        step(v, "rp0");
        step(v, "rp1");
        v.redirect = 1'b1;
        step(v, "rp2");
        step(v, "rp3");
        v = idle(); v.mem_req = 1'b1; v.mem_ack = 1'b1; v.e_rst = RS_FL; step(v, "rp_ack");
        step(idle(), "rp_after");

        // Watchdog: request never acked, timeout on 5th wait-state cycle
        v = idle(); v.mem_req = 1'b1; v.e_en = EN_MEMW; v.e_rst = RS_MEMW;
        for (int i = 0; i < 5; i++) step(v, $sformatf("to%0d", i));
        v = idle(); v.mem_req = 1'b1; v.e_tmo = 1'b1; step(v, "to_fire");
        step(idle(), "to_after");

        // Reset while a redirect is pending discards it
        v = idle(); v.mem_req = 1'b1; v.e_en = EN_MEMW; v.e_rst = RS_MEMW;
        step(v, "rm0");
        v.redirect = 1'b1; step(v, "rm1");
        v = idle(); v.rstn = 1'b0; v.mem_req = 1'b1; v.e_rst = RS_ALL; step(v, "rm_rst");
        step(idle(), "rm_rel");
        v = idle(); v.mem_req = 1'b1; v.mem_ack = 1'b1; step(v, "rm_ack");

        // Some counted activity after the reset, then a closing idle cycle
        v = idle(); v.src_addr = {5'd0, 5'd5}; v.src_used = 2'b01; v.exe_wen = 1'b1;
        v.exe_is_load = 1'b1; v.exe_waddr = 5'd5; v.e_stall = 1'b1; v.e_en = EN_LDS; v.e_rst = RS_LDS;
        step(v, "pf_ld");
        v = idle(); v.mem_req = 1'b1; v.e_en = EN_MEMW; v.e_rst = RS_MEMW; step(v, "pf_mw");
        v = idle(); v.mem_req = 1'b1; v.mem_ack = 1'b1; v.redirect = 1'b1; v.e_rst = RS_FL; step(v, "pf_fl");
        step(idle(), "final");

`ifdef HAZARD_PERF_EN
        cmp("perf", "stall_cyc", perf_stall_cyc, 32'(t_stall));
        cmp("perf", "mem_cyc",   perf_mem_cyc,   32'(t_mem));
        cmp("perf", "flush_cnt", 32'(perf_flush_cnt), 32'(t_flush));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and stage-control unit for the 5-stage MIPS pipeline (IF/ID/EXE/MEM/WB). It generalises the load-use stall and forwarding logic to NUM_SRC source operands and configurable register-address width. It adds three things:
- a registered memory-wait state machine with a req/ack handshake and a timeout watchdog;
- control-flow flush of a configurable depth;
- deferral of a redirect that arrives while the memory stage is stalled.

It sits beside the decoder and drives every stage's rst/en.

Parameters:
RA_W, 5, register address width.
NUM_SRC, 2, source operands checked per ID instruction (1..4).
FLUSH_DEPTH, 1, younger stages cleared on redirect: 1 = IF/ID only; 2 = IF/ID and ID/EXE.
TMO_W, 8, width of the memory-wait watchdog counter.
TMO_MAX, 200, wait cycles before timeout fires (must be < 2**TMO_W).

Ports:
clk  in  1  main clock
rst_n  in  1  asynchronous active-low reset
id_src_addr  in  NUM_SRC*RA_W  source register addresses, operand i at [i*RA_W +: RA_W]
id_src_used  in  NUM_SRC  operand i is read
id_is_store  in  1  ID instruction is a store (its data operand is covered by fwd_mem)
exe_wen, exe_is_load  in  1,1  EXE writes a register / EXE is a load
exe_waddr  in  RA_W  EXE destination
mem_wen, mem_is_load, mem_is_store  in  1,1,1  MEM stage flags
mem_waddr, mem_rt_addr  in  RA_W,RA_W  MEM destination / MEM store-data source register
wb_wen  in  1  WB write enable
wb_waddr  in  RA_W  WB destination
mem_req  in  1  MEM stage is accessing memory this cycle
mem_ack  in  1  memory access complete
redirect  in  1  taken branch/jump resolved in ID
fwd_sel  out  2*NUM_SRC  per operand: 0 regfile, 1 EXE ALU, 2 MEM ALU, 3 MEM load data
fwd_mem  out  1  forward WB data to store data
if_en, id_en, exe_en, mem_en, wb_en  out  1 each  stage enables
if_rst, id_rst, exe_rst, mem_rst, wb_rst  out  1 each  stage resets (insert bubble)
load_stall  out  1  load-use stall active
mem_timeout  out  1  one-cycle pulse when the watchdog expires

Behaviour:
- Reset: while rst_n=0, all *_rst=1, all *_en=1, fwd_sel=0, fwd_mem=0, load_stall=0, mem_timeout=0. The FSM goes to RUN and the counter to 0 immediately (asynchronous). Release is synchronous to the next clk edge.
- Forwarding (combinational), per operand i, applied only when used, addr!=0 and !(id_is_store && i==1):
  - EXE match with exe_wen: if exe_is_load, set load_stall; otherwise fwd=1.
  - Else MEM match with mem_wen: fwd=3 if mem_is_load, else 2.
  - The nearest stage wins.
- fwd_mem = mem_is_store & wb_wen & mem_rt_addr!=0 & wb_waddr==mem_rt_addr.
- FSM states, registered:
  - RUN → MEM_WAIT when mem_req & !mem_ack.
  - MEM_WAIT → RUN on mem_ack, or on timeout.
  - REDIR_PEND: entered from MEM_WAIT if redirect is seen; exits to RUN on ack or timeout, performing the flush in that same cycle.
- Stage control, by priority (highest first):
  1. MEM_WAIT/REDIR_PEND, or RUN with mem_req & !mem_ack: IF/ID/EXE/MEM en=0, wb_rst=1. Same-cycle ack means no stall.
  2. Redirect (live, or pending on exit): if_rst=1 when FLUSH_DEPTH=1. When FLUSH_DEPTH=2, id_rst=1 as well. This overrides load_stall, because the stalled instruction is discarded.
  3. load_stall: if_en=id_en=0, exe_rst=1.
  4. Otherwise all stages run.
- Redirect during memory wait is latched once; further redirects while pending are ORed, giving a single flush.
- Watchdog:
  - The counter clears in RUN and increments each MEM_WAIT/REDIR_PEND cycle.
  - When count==TMO_MAX-1 and there is no ack, mem_timeout pulses for 1 cycle and the FSM returns to RUN. The access is abandoned with the MEM instruction unchanged.
  - The counter saturates and never wraps.
- Reset mid-wait discards any pending redirect.

Optional Feature:
HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cyc[31:0], perf_mem_cyc[31:0] and perf_flush_cnt[15:0].
  - perf_stall_cyc counts load_stall cycles.
  - perf_mem_cyc counts memory-wait cycles.
  - perf_flush_cnt counts flushes performed.
  - All three saturate at all-ones and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: FSM state encoding (RUN/MEM_WAIT/REDIR_PEND) and fwd_sel codes FWD_RF/FWD_EXE/FWD_MEM_ALU/FWD_MEM_LD, defined in the existing define header alongside the PC_* codes.
- One sub-module, fwd_match: per-operand combinational compare. It is instantiated NUM_SRC times via generate and returns {fwd code, stall}.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with mem_req=1 → all *_rst=1, fwd_sel=0. Release → state RUN, all *_en=1.
2. EXE add writing r5 with ID using r5 as op0 → fwd_sel[1:0]=1. Same with exe_is_load=1 → load_stall=1, if_en=id_en=0, exe_rst=1. Next cycle the load is in MEM → fwd_sel[1:0]=3.
3. mem_req=1, ack after 4 cycles → IF–MEM en=0 for exactly 4 cycles, wb_rst=1, then resume. Ack in the same cycle as the request → no stall.
4. Redirect in cycle 2 of a memory wait → no flush until ack. On the ack cycle if_rst=1 (FLUSH_DEPTH=1), plus id_rst=1 when FLUSH_DEPTH=2.
5. TMO_MAX=5 with ack never asserted → mem_timeout pulses on the 5th wait cycle and the FSM returns to RUN.
6. Store in MEM reading r7 with WB writing r7 → fwd_mem=1. With r0 → fwd_mem=0. With HAZARD_PERF_EN, the counters match the cycle counts of scenarios 2–4.
